spi_req_arbiter: RTL and testbench

//  AXI-Lite master that shares one AXI_SPI_top peripheral among N_REQ local requesters.

---
 rtl/spi_arb_pkg.sv | 25 ++
 rtl/spi_req_arbiter_rr_arbiter.sv | 36 +++
 rtl/spi_req_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Purpose: shared register map, STATUS bit position and FSM state encoding for spi_req_arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spi_arb_pkg;

  // Register offsets inside the SPI peripheral window
  localparam logic [31:0] TXDATA_OFF = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFF = 32'h0000_0008;
  localparam logic [31:0] RXDATA_OFF = 32'h0000_000C;

  // STATUS[0] reads 1 while a shift is in progress
  localparam int STATUS_BUSY_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_TX   = 3'd1,
    ST_POLL_AR = 3'd2,
    ST_POLL_R  = 3'd3,
    ST_GAP     = 3'd4,
    ST_RX_AR   = 3'd5,
    ST_RX_R    = 3'd6,
    ST_DONE    = 3'd7
  } state_e;

endpackage

// File: rtl/spi_req_arbiter_rr_arbiter.sv
// Purpose: round-robin pick of the first active request at or after ptr_i (wrapping).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample the grant.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PW-1:0]    idx_o,
  output logic             vld_o
);

  logic [PW:0] scan_idx;

  // Walk the requesters starting at the pointer; the first hit wins
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    vld_o    = 1'b0;
    scan_idx = '0;
    for (int off = 0; off < N_REQ; off++) begin
      scan_idx = {1'b0, ptr_i} + (PW+1)'(off);
      if (scan_idx >= (PW+1)'(N_REQ)) begin
        scan_idx = scan_idx - (PW+1)'(N_REQ);
      end
      if (!vld_o && req_i[scan_idx[PW-1:0]]) begin
        vld_o                    = 1'b1;
        gnt_o[scan_idx[PW-1:0]]  = 1'b1;
        idx_o                    = scan_idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Purpose: AXI-Lite master sharing one SPI peripheral among N_REQ requesters (write TX, poll, read RX).
// Latency: req sampled to done pulse is 9 cycles when each READY comes one cycle after VALID,
//          RVALID follows the AR handshake by one cycle, and STATUS is not busy on the first poll.
// Backpressure: every VALID holds with stable address/data until its READY; RREADY is only raised while a read is owed.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int          N_REQ     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          POLL_GAP  = 4,
  parameter int          MAX_POLLS = 255
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [7:0]         rdata,
  output logic               err,
  output logic               AWVALID,
  input  logic               AWREADY,
  output logic [31:0]        AWADDR,
  output logic               WVALID,
  input  logic               WREADY,
  output logic [31:0]        WDATA,
  output logic               ARVALID,
  input  logic               ARREADY,
  output logic [31:0]        ARADDR,
  input  logic               RVALID,
  output logic               RREADY,
  input  logic [31:0]        RDATA
);

  localparam int         PW          = $clog2(N_REQ);
  localparam int         GW          = $clog2(POLL_GAP + 1);
  localparam logic [7:0] MAX_POLLS_W = 8'(MAX_POLLS);

  state_e             state_q;
  logic [PW-1:0]      owner_q;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW:0]        ptr_inc;
  logic [7:0]         poll_cnt_q, poll_cnt_d;
  logic [GW-1:0]      gap_cnt_q;
  logic [N_REQ-1:0]   gnt_q, done_q;
  logic               err_q;
  logic [7:0]         rdata_q;
  logic               awvalid_q, wvalid_q, arvalid_q, rready_q;
  logic [31:0]        awaddr_q, wdata_q, araddr_q;

  logic [N_REQ-1:0]   arb_gnt;
  logic [PW-1:0]      arb_idx;
  logic               arb_vld;
  logic               aw_clear, w_clear;
  logic               unused_rdata_hi;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  // Next pointer is the requester after the current owner, wrapping at N_REQ
  assign ptr_inc    = {1'b0, owner_q} + (PW+1)'(1);
  assign rr_ptr_d   = (ptr_inc >= (PW+1)'(N_REQ)) ? '0 : ptr_inc[PW-1:0];
  assign poll_cnt_d = poll_cnt_q + 8'd1;

  // A write channel is finished once its VALID has already dropped or is handshaking now
  assign aw_clear = !awvalid_q || AWREADY;
  assign w_clear  = !wvalid_q  || WREADY;

  // Only the low byte of RDATA carries data and the busy flag
  assign unused_rdata_hi = ^RDATA[31:8];

  // Transaction sequencer: owns every registered output and the AXI channel state
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      araddr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_vld) begin
            gnt_q      <= arb_gnt;
            owner_q    <= arb_idx;
            wdata_q    <= {24'h0, req_wdata[{arb_idx, 3'b000} +: 8]};
            awaddr_q   <= BASE_ADDR + TXDATA_OFF;
            awvalid_q  <= 1'b1;
            wvalid_q   <= 1'b1;
            poll_cnt_q <= '0;
            state_q    <= ST_WR_TX;
          end
        end
        ST_WR_TX: begin
          if (awvalid_q && AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && WREADY)   wvalid_q  <= 1'b0;
          if (aw_clear && w_clear) begin
            araddr_q  <= BASE_ADDR + STATUS_OFF;
            arvalid_q <= 1'b1;
            state_q   <= ST_POLL_AR;
          end
        end
        ST_POLL_AR: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_POLL_R;
          end
        end
        ST_POLL_R: begin
          if (RVALID && rready_q) begin
            rready_q <= 1'b0;
            if (!RDATA[STATUS_BUSY_BIT]) begin
              araddr_q  <= BASE_ADDR + RXDATA_OFF;
              arvalid_q <= 1'b1;
              state_q   <= ST_RX_AR;
            end else begin
              poll_cnt_q <= poll_cnt_d;
              if (poll_cnt_d == MAX_POLLS_W) begin
                // Peripheral never went idle: give up, report error with a zero byte
                done_q  <= gnt_q;
                gnt_q   <= '0;
                err_q   <= 1'b1;
                rdata_q <= '0;
                state_q <= ST_DONE;
              end else begin
                gap_cnt_q <= '0;
                state_q   <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GW'(POLL_GAP - 1)) begin
            araddr_q  <= BASE_ADDR + STATUS_OFF;
            arvalid_q <= 1'b1;
            state_q   <= ST_POLL_AR;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        ST_RX_AR: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RX_R;
          end
        end
        ST_RX_R: begin
          if (RVALID && rready_q) begin
            rready_q <= 1'b0;
            rdata_q  <= RDATA[7:0];
            done_q   <= gnt_q;
            gnt_q    <= '0;
            err_q    <= 1'b0;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q   <= '0;
          err_q    <= 1'b0;
          rr_ptr_q <= rr_ptr_d;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign err     = err_q;
  assign AWVALID = awvalid_q;
  assign AWADDR  = awaddr_q;
  assign WVALID  = wvalid_q;
  assign WDATA   = wdata_q;
  assign ARVALID = arvalid_q;
  assign ARADDR  = araddr_q;
  assign RREADY  = rready_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Purpose: scoreboard bench for spi_req_arbiter against a small AXI-Lite SPI slave model.
// Latency: slave raises READY one cycle after VALID (programmable per write channel), RVALID one cycle after AR.
// Backpressure: write READY delays are varied to skew the AW and W handshakes.
module tb_spi_req_arbiter;

  localparam int          N    = 2;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          PG   = 4;
  localparam int          MP   = 6;

  logic         ACLK = 1'b0;
  logic         ARESETn = 1'b0;
  logic [N-1:0] req;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0] gnt, done;
  logic [7:0]   rdata;
  logic         err;
  logic         AWVALID, AWREADY, WVALID, WREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0]  AWADDR, WDATA, ARADDR, RDATA;

  always #5 ACLK = ~ACLK;

  spi_req_arbiter #(
    .N_REQ(N), .BASE_ADDR(BASE), .POLL_GAP(PG), .MAX_POLLS(MP)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .req(req), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {15'h0, gnt, done, rdata, err, AWVALID, WVALID, ARVALID, RREADY, AWADDR, WDATA, ARADDR};
  endfunction

  // ---------------- slave model ----------------
  int         aw_delay = 1, w_delay = 1;
  int         busy_n = 0;
  bit         stuck = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  int         aw_cnt, w_cnt, ar_cnt, stat_polls;

  assign AWREADY = AWVALID && (aw_cnt >= aw_delay);
  assign WREADY  = WVALID  && (w_cnt  >= w_delay);
  assign ARREADY = ARVALID && (ar_cnt >= 1);

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; stat_polls <= 0;
      RVALID <= 1'b0; RDATA <= 32'h0;
    end else begin
      aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (WVALID  && !WREADY)  ? w_cnt  + 1 : 0;
      ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
      if (AWVALID && AWREADY) stat_polls <= 0;
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1;
        if (ARADDR == BASE + 32'h8) begin
          RDATA      <= {31'h0, (stuck || (stat_polls < busy_n))};
          stat_polls <= stat_polls + 1;
        end else begin
          RDATA <= {24'hC0FFEE, rx_byte};
        end
      end else if (RVALID && RREADY) begin
        RVALID <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
  logic [14:0] exp_done[$];

  task automatic expect_txn(input int own, input logic [7:0] wb, input int nbusy,
                            input bit abort, input logic [7:0] rb);
    logic [1:0] o1;
    int polls;
    o1 = (own == 0) ? 2'b01 : 2'b10;
    polls = abort ? MP : nbusy + 1;
    exp_aw.push_back(BASE);
    exp_w.push_back({24'h0, wb});
    for (int i = 0; i < polls; i++) exp_ar.push_back(BASE + 32'h8);
    if (!abort) exp_ar.push_back(BASE + 32'hC);
    exp_done.push_back({o1, o1, 2'b00, (abort ? 8'h00 : rb), abort});
  endtask

  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awaddr, p_wdata, p_araddr, last_ar;
  logic [1:0]  p_gnt;
  bit          gap_arm;
  int          gap_cnt;

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
      p_awaddr = 0; p_wdata = 0; p_araddr = 0; last_ar = 0; p_gnt = 0;
      gap_arm = 0; gap_cnt = 0;
    end else begin
      if (p_awv && !p_awr) check("aw_hold", {AWVALID, AWADDR}, {1'b1, p_awaddr});
      if (p_awv && p_awr)  check("aw_drop", AWVALID, 0);
      if (p_wv && !p_wr)   check("w_hold", {WVALID, WDATA}, {1'b1, p_wdata});
      if (p_wv && p_wr)    check("w_drop", WVALID, 0);
      if (p_arv && !p_arr) check("ar_hold", {ARVALID, ARADDR}, {1'b1, p_araddr});
      if (p_arv && p_arr)  check("ar_drop", ARVALID, 0);
      if (AWVALID && AWREADY) begin
        check("aw_expected", exp_aw.size() != 0, 1);
        if (exp_aw.size() != 0) check("aw_addr", AWADDR, exp_aw.pop_front());
      end
      if (WVALID && WREADY) begin
        check("w_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) check("w_data", WDATA, exp_w.pop_front());
      end
      if (ARVALID && ARREADY) begin
        check("ar_expected", exp_ar.size() != 0, 1);
        if (exp_ar.size() != 0) check("ar_addr", ARADDR, exp_ar.pop_front());
        last_ar = ARADDR;
      end
      if (done != 0) begin
        check("done_expected", exp_done.size() != 0, 1);
        if (exp_done.size() != 0)
          check("done_rec{done,prev_gnt,gnt,rdata,err}", {done, p_gnt, gnt, rdata, err}, exp_done.pop_front());
        gap_arm = 0;
      end
      if (gap_arm) begin
        if (ARVALID) begin
          if (ARADDR == BASE + 32'h8) check("poll_gap", gap_cnt, PG);
          gap_arm = 0;
        end else begin
          gap_cnt++;
        end
      end
      if (RVALID && RREADY && last_ar == BASE + 32'h8) begin
        gap_arm = 1;
        gap_cnt = 0;
      end
      p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
      p_wv  = WVALID;  p_wr  = WREADY;  p_wdata  = WDATA;
      p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
      p_gnt = gnt;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input string name, input int max, output int cyc);
    cyc = 0;
    while (cyc < max) begin
      @(posedge ACLK); #1;
      cyc++;
      if (done != 0) break;
    end
    if (done == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: done not seen within %0d cycles", name, max);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  initial begin : main
    int cyc;
    req = '0;
    req_wdata = '0;
    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    check("reset_outputs", outs(), 0);
    ARESETn = 1'b1;
    idle(2);
    check("idle_quiet", outs(), 0);

    // single requester, busy clears on first poll
    rx_byte = 8'h3C; busy_n = 0;
    expect_txn(0, 8'hA5, 0, 0, 8'h3C);
    req_wdata = 16'h00A5; req = 2'b01;
    @(posedge ACLK); #1;
    check("t1_gnt", gnt, 2'b01);
    wait_done("t1_done", 40, cyc);
    check("t1_latency", cyc + 1, 9);
    check("t1_rdata", rdata, 8'h3C);
    req = 2'b00;
    idle(3);
    check("t1_idle_after", {gnt, done, AWVALID, ARVALID}, 0);

    // write channels handshake in either order
    rx_byte = 8'h81; req_wdata = 16'h7700;
    aw_delay = 1; w_delay = 4;
    expect_txn(1, 8'h77, 0, 0, 8'h81);
    req = 2'b10;
    wait_done("t2a_done", 60, cyc);
    req = 2'b00;
    idle(2);
    aw_delay = 4; w_delay = 1;
    expect_txn(1, 8'h77, 0, 0, 8'h81);
    req = 2'b10;
    wait_done("t2b_done", 60, cyc);
    req = 2'b00;
    idle(2);
    aw_delay = 1; w_delay = 1;

    // both requesting continuously: 0,1,0,1
    rx_byte = 8'h5A; req_wdata = 16'h2211;
    for (int k = 0; k < 4; k++) expect_txn(k % 2, (k % 2) ? 8'h22 : 8'h11, 0, 0, 8'h5A);
    req = 2'b11;
    for (int k = 0; k < 4; k++) wait_done("t3_done", 40, cyc);
    req = 2'b00;
    idle(3);

    // five busy polls then idle
    rx_byte = 8'hE7; busy_n = 5; req_wdata = 16'h00C3;
    expect_txn(0, 8'hC3, 5, 0, 8'hE7);
    req = 2'b01;
    wait_done("t4_done", 200, cyc);
    req = 2'b00; busy_n = 0;
    idle(3);

    // stuck busy aborts owner 1, then owner 0 proceeds
    stuck = 1'b1; rx_byte = 8'h4B; req_wdata = 16'h9655;
    expect_txn(1, 8'h96, 0, 1, 8'h00);
    expect_txn(0, 8'h55, 0, 0, 8'h4B);
    req = 2'b11;
    wait_done("t5_err_done", 200, cyc);
    check("t5_err", {err, rdata}, {1'b1, 8'h00});
    stuck = 1'b0;
    req = 2'b01;
    wait_done("t5_next_done", 60, cyc);
    req = 2'b00;
    idle(3);

    // async reset while waiting on STATUS read data
    req_wdata = 16'h3344;
    exp_aw.push_back(BASE);
    exp_w.push_back(32'h33);
    exp_ar.push_back(BASE + 32'h8);
    req = 2'b11;
    @(posedge ACLK); #1;
    check("t6_gnt_ptr1", gnt, 2'b10);
    cyc = 0;
    while (cyc < 40 && !RREADY) begin
      @(posedge ACLK); #1;
      cyc++;
    end
    check("t6_reach_poll_r", RREADY, 1);
    ARESETn = 1'b0;
    #1;
    check("t6_async_reset", outs(), 0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    rx_byte = 8'h6D;
    expect_txn(0, 8'h44, 0, 0, 8'h6D);
    @(posedge ACLK); #1;
    check("t6_regrant_ptr0", gnt, 2'b01);
    wait_done("t6_done", 40, cyc);
    req = 2'b00;
    idle(3);

    check("sb_drained", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
